// File: rtl/uart_fifo_core.sv
// uart_fifo_core: UART transceiver with baud generator, RX glitch filter,
// TX/RX framing engines and TX/RX FIFOs on valid/ready streams.
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   rx_i / tx_o                      serial lines
//   tx_data_i/tx_valid_i/tx_ready_o  TX stream into the TX FIFO
//   rx_data_o/rx_valid_o/rx_ready_i  RX stream from the show-ahead RX FIFO
//   tx_en_i, rx_en_i                 allow frame starts / start detection
//   parity_en_i, parity_odd_i        parity present / odd parity
//   stop2_i                          TX sends two stop bits
//   bauds_lim_i                      baud tick period minus 1
//   err_clr_i                        clear sticky error flags
//   tx_done_o, rx_done_o             end-of-frame pulses
//   tx_busy_o                        TX engine active
//   tx_level_o, rx_level_o           FIFO occupancy
//   frame_err_o, parity_err_o, overrun_o  sticky error flags
module uart_fifo_core #(
  parameter int DATA_W     = 8,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        rx_i,
  output logic                        tx_o,
  input  logic [DATA_W-1:0]           tx_data_i,
  input  logic                        tx_valid_i,
  output logic                        tx_ready_o,
  output logic [DATA_W-1:0]           rx_data_o,
  output logic                        rx_valid_o,
  input  logic                        rx_ready_i,
  input  logic                        tx_en_i,
  input  logic                        rx_en_i,
  input  logic                        parity_en_i,
  input  logic                        parity_odd_i,
  input  logic                        stop2_i,
  input  logic [15:0]                 bauds_lim_i,
  input  logic                        err_clr_i,
  output logic                        tx_done_o,
  output logic                        rx_done_o,
  output logic                        tx_busy_o,
  output logic [$clog2(FIFO_DEPTH):0] tx_level_o,
  output logic [$clog2(FIFO_DEPTH):0] rx_level_o,
  output logic                        frame_err_o,
  output logic                        parity_err_o,
  output logic                        overrun_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVS / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_W - 1);
  localparam logic [LW-1:0] FULL_CNT  = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- baud generator ----------------
  // The limit is only reloaded at a wrap (or while stopped) so a new period
  // never truncates a tick interval already in progress.
  logic [15:0] baud_cnt_reg, baud_lim_reg;
  logic        baud_run, tick;

  assign baud_run = tx_en_i | rx_en_i | tx_busy_o;
  assign tick     = baud_run && (baud_cnt_reg == baud_lim_reg);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      baud_cnt_reg <= '0;
      baud_lim_reg <= '0;
    end else if (!baud_run || tick) begin
      baud_cnt_reg <= '0;
      baud_lim_reg <= bauds_lim_i;
    end else begin
      baud_cnt_reg <= baud_cnt_reg + 16'd1;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]     tx_wr_reg, tx_rd_reg;
  logic [LW-1:0]     tx_cnt_reg, tx_cnt_next;
  logic              tx_rdy_reg, tx_push, tx_start;
  logic [DATA_W-1:0] tx_head;

  assign tx_push    = tx_valid_i & tx_rdy_reg;
  assign tx_head    = tx_mem[tx_rd_reg];
  assign tx_ready_o = tx_rdy_reg;
  assign tx_level_o = tx_cnt_reg;

  always_comb begin
    tx_cnt_next = tx_cnt_reg;
    if (tx_push && !tx_start)      tx_cnt_next = tx_cnt_reg + LW'(1);
    else if (!tx_push && tx_start) tx_cnt_next = tx_cnt_reg - LW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_wr_reg  <= '0;
      tx_rd_reg  <= '0;
      tx_cnt_reg <= '0;
      tx_rdy_reg <= 1'b0;
    end else begin
      if (tx_push)  tx_wr_reg <= tx_wr_reg + AW'(1);
      if (tx_start) tx_rd_reg <= tx_rd_reg + AW'(1);
      tx_cnt_reg <= tx_cnt_next;
      // Ready comes from the registered next count: no path from the pop side.
      tx_rdy_reg <= (tx_cnt_next != FULL_CNT);
    end
  end

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_reg] <= tx_data_i;
  end

  // ---------------- TX FSM ----------------
  state_t            tx_state_reg, tx_state_next;
  logic [CW-1:0]     tx_tick_reg;
  logic [3:0]        tx_bit_reg;
  logic [DATA_W-1:0] tx_sh_reg;
  logic              tx_par_reg, tx_par_en_reg, tx_stop2_reg, tx_line_reg;
  logic              tx_bit_end, tx_last_data, tx_last_stop;

  assign tx_start     = (tx_state_reg == S_IDLE) && tick && tx_en_i && (tx_cnt_reg != '0);
  assign tx_bit_end   = tick && (tx_tick_reg == BIT_LAST);
  assign tx_last_data = (tx_bit_reg == DATA_LAST);
  assign tx_last_stop = (tx_bit_reg == {3'b000, tx_stop2_reg});
  assign tx_o         = tx_line_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tx_state_reg <= S_IDLE;
    else       tx_state_reg <= tx_state_next;
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    case (tx_state_reg)
      S_IDLE:   if (tx_start) tx_state_next = S_START;
      S_START:  if (tx_bit_end) tx_state_next = S_DATA;
      S_DATA:   if (tx_bit_end && tx_last_data) tx_state_next = tx_par_en_reg ? S_PARITY : S_STOP;
      S_PARITY: if (tx_bit_end) tx_state_next = S_STOP;
      S_STOP:   if (tx_bit_end && tx_last_stop) tx_state_next = S_IDLE;
      default:  tx_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_busy_o = (tx_state_reg != S_IDLE);
    tx_done_o = (tx_state_reg == S_STOP) && tx_bit_end && tx_last_stop;
  end

  // Line value is registered and updated at each bit boundary.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_tick_reg   <= '0;
      tx_bit_reg    <= '0;
      tx_sh_reg     <= '0;
      tx_par_reg    <= 1'b0;
      tx_par_en_reg <= 1'b0;
      tx_stop2_reg  <= 1'b0;
      tx_line_reg   <= 1'b1;
    end else if (tx_start) begin
      tx_sh_reg     <= tx_head;
      tx_par_reg    <= (^tx_head) ^ parity_odd_i;
      tx_par_en_reg <= parity_en_i;
      tx_stop2_reg  <= stop2_i;
      tx_tick_reg   <= '0;
      tx_bit_reg    <= '0;
      tx_line_reg   <= 1'b0;
    end else if ((tx_state_reg != S_IDLE) && tick) begin
      if (tx_tick_reg == BIT_LAST) begin
        tx_tick_reg <= '0;
        case (tx_state_reg)
          S_START: begin
            tx_bit_reg  <= '0;
            tx_line_reg <= tx_sh_reg[0];
          end
          S_DATA: begin
            if (tx_last_data) begin
              tx_bit_reg  <= '0;
              tx_line_reg <= tx_par_en_reg ? tx_par_reg : 1'b1;
            end else begin
              tx_bit_reg  <= tx_bit_reg + 4'd1;
              tx_sh_reg   <= tx_sh_reg >> 1;
              tx_line_reg <= tx_sh_reg[1];
            end
          end
          S_PARITY: begin
            tx_bit_reg  <= '0;
            tx_line_reg <= 1'b1;
          end
          S_STOP: begin
            tx_bit_reg  <= tx_bit_reg + 4'd1;
            tx_line_reg <= 1'b1;
          end
          default: tx_line_reg <= 1'b1;
        endcase
      end else begin
        tx_tick_reg <= tx_tick_reg + CW'(1);
      end
    end
  end

  // ---------------- RX input filter ----------------
  // Two-flop synchroniser, 3-sample window, registered majority vote.
  // Everything resets to the idle level so reset never looks like a start.
  logic       rx_sync1_reg, rx_sync2_reg, rx_filt_reg;
  logic [2:0] rx_win_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_sync1_reg <= 1'b1;
      rx_sync2_reg <= 1'b1;
      rx_win_reg   <= 3'b111;
      rx_filt_reg  <= 1'b1;
    end else begin
      rx_sync1_reg <= rx_i;
      rx_sync2_reg <= rx_sync1_reg;
      rx_win_reg   <= {rx_win_reg[1:0], rx_sync2_reg};
      rx_filt_reg  <= (rx_win_reg[0] & rx_win_reg[1]) | (rx_win_reg[0] & rx_win_reg[2]) |
                      (rx_win_reg[1] & rx_win_reg[2]);
    end
  end

  // ---------------- RX FSM ----------------
  state_t            rx_state_reg, rx_state_next;
  logic [CW-1:0]     rx_tick_reg;
  logic [3:0]        rx_bit_reg;
  logic [DATA_W-1:0] rx_sh_reg;
  logic              rx_par_bit_reg, rx_par_en_reg, rx_par_odd_reg;
  logic              rx_start, rx_half, rx_samp, rx_last_data;
  logic              rx_stop_ok, rx_stop_bad, rx_par_bad, rx_push, rx_pop, rx_full, rx_ovr_set;

  assign rx_start     = (rx_state_reg == S_IDLE) && tick && rx_en_i && !rx_filt_reg;
  assign rx_half      = tick && (rx_tick_reg == HALF_LAST);
  assign rx_samp      = tick && (rx_tick_reg == BIT_LAST);
  assign rx_last_data = (rx_bit_reg == DATA_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rx_state_reg <= S_IDLE;
    else       rx_state_reg <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    case (rx_state_reg)
      S_IDLE:   if (rx_start) rx_state_next = S_START;
      // Re-sample mid start bit; a high line here was only noise.
      S_START:  if (rx_half) rx_state_next = rx_filt_reg ? S_IDLE : S_DATA;
      S_DATA:   if (rx_samp && rx_last_data) rx_state_next = rx_par_en_reg ? S_PARITY : S_STOP;
      S_PARITY: if (rx_samp) rx_state_next = S_STOP;
      S_STOP:   if (rx_samp) rx_state_next = S_IDLE;
      default:  rx_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_stop_ok  = (rx_state_reg == S_STOP) && rx_samp && rx_filt_reg;
    rx_stop_bad = (rx_state_reg == S_STOP) && rx_samp && !rx_filt_reg;
    rx_par_bad  = rx_par_en_reg && ((^rx_sh_reg) ^ rx_par_bit_reg ^ rx_par_odd_reg);
    // A full FIFO still accepts the frame if its head leaves this cycle.
    rx_push     = rx_stop_ok && (!rx_full || rx_pop);
    rx_ovr_set  = rx_stop_ok && rx_full && !rx_pop;
    rx_done_o   = rx_push;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_tick_reg    <= '0;
      rx_bit_reg     <= '0;
      rx_sh_reg      <= '0;
      rx_par_bit_reg <= 1'b0;
      rx_par_en_reg  <= 1'b0;
      rx_par_odd_reg <= 1'b0;
    end else if (rx_start) begin
      rx_tick_reg    <= '0;
      rx_bit_reg     <= '0;
      rx_par_en_reg  <= parity_en_i;
      rx_par_odd_reg <= parity_odd_i;
    end else if ((rx_state_reg != S_IDLE) && tick) begin
      if ((rx_state_reg == S_START) ? (rx_tick_reg == HALF_LAST) : (rx_tick_reg == BIT_LAST)) begin
        rx_tick_reg <= '0;
        if (rx_state_reg == S_DATA) begin
          rx_sh_reg  <= {rx_filt_reg, rx_sh_reg[DATA_W-1:1]};
          rx_bit_reg <= rx_last_data ? 4'd0 : rx_bit_reg + 4'd1;
        end
        if (rx_state_reg == S_PARITY) rx_par_bit_reg <= rx_filt_reg;
      end else begin
        rx_tick_reg <= rx_tick_reg + CW'(1);
      end
    end
  end

  // ---------------- RX FIFO (show-ahead) ----------------
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     rx_wr_reg, rx_rd_reg;
  logic [LW-1:0]     rx_cnt_reg;

  assign rx_full    = (rx_cnt_reg == FULL_CNT);
  assign rx_valid_o = (rx_cnt_reg != '0);
  assign rx_pop     = rx_valid_o & rx_ready_i;
  assign rx_data_o  = rx_valid_o ? rx_mem[rx_rd_reg] : '0;
  assign rx_level_o = rx_cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_wr_reg  <= '0;
      rx_rd_reg  <= '0;
      rx_cnt_reg <= '0;
    end else begin
      if (rx_push) rx_wr_reg <= rx_wr_reg + AW'(1);
      if (rx_pop)  rx_rd_reg <= rx_rd_reg + AW'(1);
      if (rx_push && !rx_pop)      rx_cnt_reg <= rx_cnt_reg + LW'(1);
      else if (!rx_push && rx_pop) rx_cnt_reg <= rx_cnt_reg - LW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wr_reg] <= rx_sh_reg;
  end

  // ---------------- sticky errors (set beats clear) ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      frame_err_o  <= rx_stop_bad | (frame_err_o & ~err_clr_i);
      parity_err_o <= (rx_stop_ok & rx_par_bad) | (parity_err_o & ~err_clr_i);
      overrun_o    <= rx_ovr_set | (overrun_o & ~err_clr_i);
    end
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: directed bench for uart_fifo_core (8 data bits, OVS=16,
// depth 8, one baud tick per clock). Covers TX framing, parity/2-stop
// loopback, backpressure/overrun, framing error, glitch rejection, error
// clear priority and asynchronous reset mid-frame.
module tb_uart_fifo_core;
  localparam int DATA_W = 8;
  localparam int OVS = 16;
  localparam int FIFO_DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_drv = 1'b1;
  logic       loop_sel = 1'b0;
  logic       rx_line;
  logic       tx_o;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       tx_en = 1'b0, rx_en = 1'b0;
  logic       parity_en = 1'b0, parity_odd = 1'b0, stop2 = 1'b0;
  logic [15:0] bauds_lim = 16'd0;
  logic       err_clr = 1'b0;
  logic       tx_done, rx_done, tx_busy;
  logic [3:0] tx_level, rx_level;
  logic       frame_err, parity_err, overrun;

  int checks = 0;
  int errors = 0;
  int tx_done_cnt = 0;
  int rx_done_cnt = 0;

  always #5 clk = ~clk;
  assign rx_line = loop_sel ? tx_o : rx_drv;

  uart_fifo_core #(.DATA_W(DATA_W), .OVS(OVS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx_line), .tx_o(tx_o),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .tx_en_i(tx_en), .rx_en_i(rx_en), .parity_en_i(parity_en),
    .parity_odd_i(parity_odd), .stop2_i(stop2), .bauds_lim_i(bauds_lim),
    .err_clr_i(err_clr), .tx_done_o(tx_done), .rx_done_o(rx_done),
    .tx_busy_o(tx_busy), .tx_level_o(tx_level), .rx_level_o(rx_level),
    .frame_err_o(frame_err), .parity_err_o(parity_err), .overrun_o(overrun)
  );

  always @(negedge clk) begin
    if (tx_done) tx_done_cnt++;
    if (rx_done) rx_done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    bit ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      if (tx_ready) ok = 1'b1;
      else @(negedge clk);
    end
    check("push_ready", ok, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pop();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // Waits for the start bit on tx_o, then checks every bit holds for OVS clocks.
  task automatic tx_expect(input string tag, input logic [7:0] d, input logic pe,
                           input logic pb, input int nstop, output logic [3:0] lvl);
    logic [15:0] bits;
    int nb;
    int ok;
    bit found;
    bits = '0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    nb = 9;
    if (pe) begin bits[nb] = pb; nb++; end
    for (int s = 0; s < nstop; s++) begin bits[nb] = 1'b1; nb++; end
    found = 1'b0;
    lvl = '1;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      if (tx_o == 1'b0) found = 1'b1;
    end
    check({tag, "_start"}, found, 1);
    if (found) begin
      lvl = tx_level;
      for (int b = 0; b < nb; b++) begin
        ok = 0;
        for (int c = 0; c < OVS; c++) begin
          if (!(b == 0 && c == 0)) @(negedge clk);
          if (tx_o == bits[b]) ok++;
        end
        check($sformatf("%s_bit%0d", tag, b), ok, OVS);
      end
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx_drv = v;
    repeat (n) @(negedge clk);
  endtask

  // Bench-driven serial frame; stop level and length are chosen by the caller.
  task automatic rx_send(input logic [7:0] d, input logic pe, input logic pb,
                         input logic stopv, input int stop_len);
    drive(1'b0, OVS);
    for (int i = 0; i < 8; i++) drive(d[i], OVS);
    if (pe) drive(pb, OVS);
    drive(stopv, stop_len);
    rx_drv = 1'b1;
  endtask

  logic [3:0] lvl;
  int d0;
  bit flag;

  initial begin
    // ---- reset state ----
    idle(3);
    check("rst_tx_o", tx_o, 1);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_levels", {tx_level, rx_level}, 0);
    check("rst_flags", {tx_busy, tx_done, rx_done, frame_err, parity_err, overrun}, 0);
    rst = 1'b0;
    idle(1);
    check("post_rst_tx_ready", tx_ready, 1);

    // ---- 8N1 TX of 0xA5 ----
    push(8'hA5);
    idle(2);
    check("a5_level_before", tx_level, 1);
    check("a5_busy_before", tx_busy, 0);
    d0 = tx_done_cnt;
    tx_en = 1'b1;
    tx_expect("a5", 8'hA5, 1'b0, 1'b0, 1, lvl);
    check("a5_level_at_start", lvl, 0);
    idle(2);
    check("a5_done_pulses", tx_done_cnt - d0, 1);
    check("a5_busy_after", tx_busy, 0);

    // ---- odd parity, 2 stop bits, loopback of 0x03 ----
    parity_en = 1'b1; parity_odd = 1'b1; stop2 = 1'b1;
    loop_sel = 1'b1; rx_en = 1'b1;
    idle(20);
    d0 = rx_done_cnt;
    push(8'h03);
    tx_expect("p03", 8'h03, 1'b1, 1'b1, 2, lvl);
    idle(10);
    check("p03_rx_level", rx_level, 1);
    check("p03_rx_data", rx_data, 8'h03);
    check("p03_rx_done", rx_done_cnt - d0, 1);
    check("p03_errs", {frame_err, parity_err, overrun}, 0);
    pop();
    check("p03_rx_level_pop", rx_level, 0);

    // flipped parity bit on the line: flagged, data still pushed
    loop_sel = 1'b0;
    rx_send(8'h03, 1'b1, 1'b0, 1'b1, OVS);
    idle(10);
    check("pbad_parity_err", parity_err, 1);
    check("pbad_rx_level", rx_level, 1);
    check("pbad_rx_data", rx_data, 8'h03);
    pop();
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    check("pbad_cleared", parity_err, 0);

    // ---- backpressure / overrun ----
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    loop_sel = 1'b1;
    idle(5);
    for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
    check("bp_tx_level_full", tx_level, 8);
    check("bp_tx_ready_full", tx_ready, 0);
    flag = 1'b0;
    for (int k = 0; k < 3000 && !flag; k++) begin
      @(negedge clk);
      if (tx_level == 0 && !tx_busy) flag = 1'b1;
    end
    check("bp_tx_drained", flag, 1);
    idle(20);
    check("bp_rx_level", rx_level, 8);
    check("bp_overrun", overrun, 1);
    check("bp_rx_valid", rx_valid, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bp_read%0d", i), rx_data, 8'h10 + 8'(i));
      pop();
    end
    check("bp_rx_level_empty", rx_level, 0);
    check("bp_rx_valid_empty", rx_valid, 0);

    // ---- framing error ----
    loop_sel = 1'b0;
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    check("ovr_cleared", overrun, 0);
    rx_send(8'h55, 1'b0, 1'b0, 1'b0, 12);
    idle(30);
    check("fe_frame_err", frame_err, 1);
    check("fe_rx_level", rx_level, 0);
    check("fe_parity_err", parity_err, 0);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    check("fe_cleared", frame_err, 0);

    // ---- glitch rejection and false start ----
    rx_drv = 1'b0; idle(1); rx_drv = 1'b1;
    idle(40);
    check("glitch_flags", {frame_err, parity_err, overrun}, 0);
    check("glitch_rx_level", rx_level, 0);
    drive(1'b0, 5);
    rx_drv = 1'b1;
    idle(40);
    check("short_flags", {frame_err, parity_err, overrun}, 0);
    check("short_rx_level", rx_level, 0);
    rx_send(8'h3C, 1'b0, 1'b0, 1'b1, OVS);
    idle(10);
    check("after_short_level", rx_level, 1);
    check("after_short_data", rx_data, 8'h3C);
    pop();

    // ---- clear in the same cycle as a new frame error ----
    flag = 1'b0;
    fork
      begin
        err_clr = 1'b1;
        rx_send(8'h66, 1'b0, 1'b0, 1'b0, 12);
      end
      begin
        for (int k = 0; k < 400 && !flag; k++) begin
          @(negedge clk);
          if (frame_err) begin
            flag = 1'b1;
            err_clr = 1'b0;
          end
        end
      end
    join
    err_clr = 1'b0;
    check("clr_set_wins", flag, 1);
    idle(1);
    check("clr_set_holds", frame_err, 1);
    idle(30);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    check("clr_alone", frame_err, 0);

    // ---- asynchronous reset in the middle of a TX frame ----
    rx_send(8'h44, 1'b0, 1'b0, 1'b0, 12);
    idle(30);
    rx_send(8'h21, 1'b0, 1'b0, 1'b1, OVS);
    idle(10);
    check("pre_rst_state", {frame_err, rx_level}, {1'b1, 4'd1});
    push(8'h5A);
    push(8'h77);
    flag = 1'b0;
    for (int k = 0; k < 100 && !flag; k++) begin
      @(negedge clk);
      if (tx_o == 1'b0) flag = 1'b1;
    end
    check("mid_start_seen", flag, 1);
    idle(20);
    check("mid_tx_low", tx_o, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_tx_o", tx_o, 1);
    check("arst_levels", {tx_level, rx_level}, 0);
    check("arst_flags", {frame_err, parity_err, overrun, tx_busy, rx_valid}, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    check("arst_ready", tx_ready, 1);
    d0 = tx_done_cnt;
    push(8'h5A);
    tx_expect("r5a", 8'h5A, 1'b0, 1'b0, 1, lvl);
    idle(2);
    check("r5a_done", tx_done_cnt - d0, 1);
    check("r5a_level", tx_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
